ifu_fetch: RTL

//   Instruction-fetch stage; producer side of the IF/ID pipeline register.

---
 rtl/ifu_fetch_pkg.sv | 39 +++
 rtl/ifu_fetch_static_bp.sv | 27 ++
 rtl/ifu_fetch.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/ifu_fetch_pkg.sv
// ifu_fetch_pkg: shared types and constants for the instruction-fetch stage.
//   - IFU state encoding (enum)
//   - bus widths / zero word / stall polarity
//   - RISC-V opcodes and immediate decode helpers used by the static predictor
package ifu_fetch_pkg;

  localparam int unsigned INST_ADDR_W = 32;
  localparam int unsigned INST_W      = 32;

  localparam logic [INST_W-1:0] ZERO_WORD = '0;
  localparam logic              STOP      = 1'b1;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_HOLD
  } ifu_state_e;

  function automatic logic is_jal(input logic [INST_W-1:0] inst);
    return inst[6:0] == OPC_JAL;
  endfunction

  function automatic logic is_branch(input logic [INST_W-1:0] inst);
    return inst[6:0] == OPC_BRANCH;
  endfunction

  function automatic logic [INST_ADDR_W-1:0] imm_j(input logic [INST_W-1:0] inst);
    return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

  function automatic logic [INST_ADDR_W-1:0] imm_b(input logic [INST_W-1:0] inst);
    return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/ifu_fetch_static_bp.sv
// ifu_static_bp: combinational BTFN static branch predictor.
//   Only built when IFU_STATIC_BP_EN is defined.
//   inst        in  32  fetched instruction word
//   pc          in  32  PC of that instruction
//   prdt_taken  out 1   JAL, or conditional branch with negative offset
//   prdt_target out 32  pc + sign-extended J/B immediate
`ifdef IFU_STATIC_BP_EN
module ifu_static_bp
  import ifu_fetch_pkg::*;
(
  input  logic [31:0] inst,
  input  logic [31:0] pc,
  output logic        prdt_taken,
  output logic [31:0] prdt_target
);

  logic jal;
  logic br;

  assign jal         = is_jal(inst);
  assign br          = is_branch(inst);
  // Backward branches (sign bit of B-imm set) are predicted taken.
  assign prdt_taken  = jal | (br & inst[31]);
  assign prdt_target = pc + (jal ? imm_j(inst) : imm_b(inst));

endmodule
`endif

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction-fetch stage, producer side of the IF/ID register.
//   Build option: IFU_STATIC_BP_EN enables BTFN static prediction.
//   clk            in   sole clock, rising edge
//   rst            in   asynchronous active-low reset
//   stall[5:0]     in   ctrl stall vector; [0]=PC stage, [1]=IF stage
//   flush/flush_pc in   redirect from EX
//   imem_req/addr  out  fetch request, word-aligned address
//   imem_gnt       in   request accepted
//   imem_rvalid/rdata in  in-order read return
//   if_pc/if_inst/if_prdt_taken out  presented instruction (all 0 = bubble)
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_prdt_taken
);

  ifu_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] buf_inst_q, buf_inst_d;
  logic        buf_prdt_q, buf_prdt_d;
  logic        drop_q, drop_d;

  logic        req_c;
  logic        present;
  logic [31:0] cur_inst;
  logic        raw_prdt;
  logic        cur_prdt;
  logic [31:0] cur_target;
  logic [31:0] seq_pc;
  logic [31:0] next_pc;
  logic        unused_stall;

  assign unused_stall = ^stall[5:2];

  assign cur_inst = (state_q == ST_HOLD) ? buf_inst_q : imem_rdata;
  assign seq_pc   = fetch_pc_q + 32'd4;

`ifdef IFU_STATIC_BP_EN
  logic [31:0] bp_target;

  ifu_static_bp u_bp (
    .inst        (cur_inst),
    .pc          (fetch_pc_q),
    .prdt_taken  (raw_prdt),
    .prdt_target (bp_target)
  );
  assign cur_target = bp_target;
`else
  assign raw_prdt   = 1'b0;
  assign cur_target = seq_pc;
`endif

  assign cur_prdt = (state_q == ST_HOLD) ? buf_prdt_q : raw_prdt;
  assign next_pc  = cur_prdt ? cur_target : seq_pc;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fetch_pc_d = fetch_pc_q;
    buf_inst_d = buf_inst_q;
    buf_prdt_d = buf_prdt_q;
    drop_d     = drop_q;
    req_c      = 1'b0;
    present    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A flush in IDLE suppresses the request so the stale pc_q never goes out.
        req_c = (stall[0] != STOP) && !flush;
        if (flush) begin
          pc_d = flush_pc;
        end else if (req_c) begin
          fetch_pc_d = pc_q;
          state_d    = imem_gnt ? ST_WAIT : ST_REQ;
        end
      end
      ST_REQ: begin
        req_c = 1'b1;
        if (flush) begin
          pc_d   = flush_pc;
          drop_d = 1'b1;
        end
        if (imem_gnt) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          state_d = ST_IDLE;
          if (drop_q) begin
            drop_d = 1'b0;
          end else if (!flush) begin
            if (stall[1] != STOP) begin
              present = 1'b1;
              pc_d    = next_pc;
            end else begin
              buf_inst_d = imem_rdata;
              buf_prdt_d = raw_prdt;
              state_d    = ST_HOLD;
            end
          end
          if (flush) pc_d = flush_pc;
        end else if (flush) begin
          pc_d   = flush_pc;
          drop_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (flush) begin
          pc_d       = flush_pc;
          buf_inst_d = '0;
          buf_prdt_d = 1'b0;
          state_d    = ST_IDLE;
        end else begin
          present = 1'b1;
          if (stall[1] != STOP) begin
            pc_d    = next_pc;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      buf_inst_q <= '0;
      buf_prdt_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fetch_pc_q <= fetch_pc_d;
      buf_inst_q <= buf_inst_d;
      buf_prdt_q <= buf_prdt_d;
      drop_q     <= drop_d;
    end
  end

  // Address comes from fetch_pc_q once a request is pending, so a flush that
  // rewrites pc_q cannot disturb an un-granted request.
  assign imem_req      = rst & req_c;
  assign imem_addr     = (state_q == ST_IDLE) ? {pc_q[31:2], 2'b00}
                                              : {fetch_pc_q[31:2], 2'b00};
  assign if_pc         = present ? fetch_pc_q : ZERO_WORD;
  assign if_inst       = present ? cur_inst : ZERO_WORD;
  assign if_prdt_taken = present & cur_prdt;

endmodule
